// File: rtl/pio_pkg.sv
// pio_pkg: shared definitions for the PIO RX sequencer.
//   - pio_action encodings driven toward the pio core
//   - field positions inside a 38-bit config entry {mindex[1:0], action[3:0], data[31:0]}
//   - sequencer state codes (LOAD -> CONF -> RUN)
//   - boot image types; the default images are blank and a wrapper overrides them
package pio_pkg;

   localparam logic [5:0] ACT_NONE  = 6'd0;
   localparam logic [5:0] ACT_INSTR = 6'd1;
   localparam logic [5:0] ACT_PULL  = 6'd3;

   localparam int CONF_W        = 38;
   localparam int CONF_DATA_LSB = 0;
   localparam int CONF_ACT_LSB  = 32;
   localparam int CONF_MIDX_LSB = 36;

   typedef logic [1:0] seq_state_t;
   localparam seq_state_t ST_LOAD = 2'd0;
   localparam seq_state_t ST_CONF = 2'd1;
   localparam seq_state_t ST_RUN  = 2'd2;

   // Boot images sized for the maximum lengths; only the first PROG_LEN / CONF_LEN entries are used.
   typedef logic [31:0][15:0]       prog_img_t;
   typedef logic [31:0][CONF_W-1:0] conf_img_t;

   localparam prog_img_t DEF_PROG_IMG = '0;
   localparam conf_img_t DEF_CONF_IMG = '0;

endpackage

// File: rtl/pio_rr_arb.sv
// pio_rr_arb: combinational round-robin pick among NUM_SM requesters.
// Ports:
//   req     in  NUM_SM  request per state machine (RX FIFO not empty)
//   ptr     in  2       first index eligible for priority
//   gnt_vld out 1       at least one request present
//   sel     out 2       first requester at or after ptr, wrapping at NUM_SM
module pio_rr_arb #(
   parameter int NUM_SM = 4
) (
   input  logic [NUM_SM-1:0] req,
   input  logic [1:0]        ptr,
   output logic              gnt_vld,
   output logic [1:0]        sel
);

   always_comb begin
      gnt_vld = |req;
      sel     = 2'd0;
      // Wrap-around fallback: lowest requester overall.
      for (int i = NUM_SM - 1; i >= 0; i--)
         if (req[i]) sel = 2'(i);
      // A requester at or after ptr takes precedence; descending scan leaves the lowest one.
      for (int i = NUM_SM - 1; i >= 0; i--)
         if (req[i] && (i >= int'(ptr))) sel = 2'(i);
   end

endmodule

// File: rtl/pio_rx_sequencer.sv
// pio_rx_sequencer: boots one PIO instance and then drains its RX FIFOs.
//   LOAD: one program word per cycle (pio_action=1, pio_index=p)
//   CONF: one config entry per cycle, fields passed through unchanged
//   RUN : round-robin pulls from non-empty SMs; each pulled word is presented on m_valid/m_data/m_sm
// Ports:
//   clk, n_reset (async, active low), restart (sync pulse, reload from index 0)
//   pio_action/pio_index/pio_mindex/pio_din  -> pio core
//   pio_dout, pio_rx_empty                   <- pio core
//   m_valid/m_data/m_sm out, m_ready in       output stream
//   running                                   high while in RUN
module pio_rx_sequencer
   import pio_pkg::*;
#(
   parameter int        NUM_SM   = 4,
   parameter int        PROG_LEN = 32,
   parameter int        CONF_LEN = 5,
   parameter int        DATA_W   = 8,
   parameter int        DATA_LSB = 24,
   parameter int        PULL_GAP = 4,
   parameter int        PULL_LAT = 2,
   parameter prog_img_t PROG_IMG = DEF_PROG_IMG,
   parameter conf_img_t CONF_IMG = DEF_CONF_IMG
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              restart,
   output logic [5:0]        pio_action,
   output logic [4:0]        pio_index,
   output logic [1:0]        pio_mindex,
   output logic [31:0]       pio_din,
   input  logic [31:0]       pio_dout,
   input  logic [NUM_SM-1:0] pio_rx_empty,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic [1:0]        m_sm,
   input  logic              m_ready,
   output logic              running
);

   seq_state_t state;
   logic [4:0] prog_cnt;
   logic [4:0] conf_cnt;
   logic [7:0] gap_cnt;
   logic [7:0] lat_cnt;
   logic [1:0] rr_ptr;
   logic [1:0] pull_sm;
   logic [1:0] sel;
   logic       any_req;
   logic       slot_free;
   logic       pull_go;
   logic       dout_unused;

   // Only the DATA_W slice of pio_dout is consumed.
   assign dout_unused = ^pio_dout;

   pio_rr_arb #(.NUM_SM(NUM_SM)) u_arb (
      .req     (~pio_rx_empty),
      .ptr     (rr_ptr),
      .gnt_vld (any_req),
      .sel     (sel)
   );

   // running is registered one cycle after entering RUN, so the first RUN cycle
   // always drives ACT_NONE. lat_cnt != 0 marks a pull in flight.
   assign slot_free = !m_valid || m_ready;
   assign pull_go   = running && (gap_cnt == 8'd0) && (lat_cnt == 8'd0) && slot_free && any_req;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state      <= ST_LOAD;
         prog_cnt   <= '0;
         conf_cnt   <= '0;
         gap_cnt    <= '0;
         lat_cnt    <= '0;
         rr_ptr     <= '0;
         pull_sm    <= '0;
         pio_action <= ACT_NONE;
         pio_index  <= '0;
         pio_mindex <= '0;
         pio_din    <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_sm       <= '0;
         running    <= 1'b0;
      end else if (restart) begin
         // Abort everything, including a pull in flight and a pending output word.
         state      <= ST_LOAD;
         prog_cnt   <= '0;
         conf_cnt   <= '0;
         gap_cnt    <= '0;
         lat_cnt    <= '0;
         rr_ptr     <= '0;
         pull_sm    <= '0;
         pio_action <= ACT_NONE;
         pio_index  <= '0;
         pio_mindex <= '0;
         pio_din    <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_sm       <= '0;
         running    <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               pio_action <= ACT_INSTR;
               pio_index  <= prog_cnt;
               pio_mindex <= 2'd0;
               pio_din    <= {16'h0000, PROG_IMG[prog_cnt]};
               if (prog_cnt == 5'(PROG_LEN - 1)) state    <= ST_CONF;
               else                              prog_cnt <= prog_cnt + 5'd1;
            end
            ST_CONF: begin
               // Action-0 entries go out unchanged and act as no-ops in the core.
               pio_action <= {2'b00, CONF_IMG[conf_cnt][CONF_ACT_LSB +: 4]};
               pio_mindex <= CONF_IMG[conf_cnt][CONF_MIDX_LSB +: 2];
               pio_din    <= CONF_IMG[conf_cnt][CONF_DATA_LSB +: 32];
               if (conf_cnt == 5'(CONF_LEN - 1)) state    <= ST_RUN;
               else                              conf_cnt <= conf_cnt + 5'd1;
            end
            default: begin
               running    <= 1'b1;
               pio_action <= pull_go ? ACT_PULL : ACT_NONE;
               if (pull_go) begin
                  pio_mindex <= sel;
                  pull_sm    <= sel;
                  rr_ptr     <= (int'(sel) == NUM_SM - 1) ? 2'd0 : sel + 2'd1;
                  // Gap spans the rx_empty update lag so a just-drained SM is not pulled twice.
                  gap_cnt    <= 8'(PULL_GAP - 1);
                  lat_cnt    <= 8'(PULL_LAT);
               end else if (gap_cnt != 8'd0) begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
               if (m_valid && m_ready) m_valid <= 1'b0;
               // pull_go needs lat_cnt == 0, so this never overlaps with a new issue.
               if (lat_cnt != 8'd0) begin
                  lat_cnt <= lat_cnt - 8'd1;
                  if (lat_cnt == 8'd1) begin
                     m_valid <= 1'b1;
                     m_data  <= pio_dout[DATA_LSB +: DATA_W];
                     m_sm    <= pull_sm;
                  end
               end
            end
         endcase
      end
   end

endmodule
